// File: rtl/ram_sync_clr.sv
// rtl/ram_sync_clr.sv - single-port synchronous RAM with masked writes and clear sweep
module ram_sync_clr #(
  parameter int                 DATA_W  = 4,
  parameter int                 ADDR_W  = 5,
  parameter int                 OUT_REG = 0,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  input  logic              clear_start,
  output logic              busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic                w_accept;
  logic                w_clr_last;

  logic                r_s1_valid;
  logic                r_s1_we;
  logic [ADDR_W-1:0]   r_s1_addr;
  logic [DATA_W-1:0]   r_s1_wdata;
  logic [DATA_W-1:0]   r_s1_wmask;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                r_rd_valid0;
  logic [DATA_W-1:0]   r_rd_data0;

  assign busy       = (r_state == ST_CLEAR);
  assign req_ready  = (r_state == ST_IDLE);
  assign w_accept   = req_valid & req_ready;
  assign w_clr_last = (r_clr_cnt == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (w_clr_last)  w_state_nxt = ST_IDLE;
      ST_IDLE:  if (clear_start) w_state_nxt = ST_CLEAR;
      default:                   w_state_nxt = ST_CLEAR;
    endcase
  end

  // Counter wraps to 0 on the last word, so a new sweep always starts at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_cnt <= '0;
    end else if (busy) begin
      r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_we    <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_wdata <= '0;
      r_s1_wmask <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_we    <= req_we;
        r_s1_addr  <= req_addr;
        r_s1_wdata <= req_wdata;
        r_s1_wmask <= req_wmask;
      end
    end
  end

  // A write still in S1 when the sweep starts is superseded by the sweep,
  // which overwrites every word, so the sweep owns the write port.
  always_ff @(posedge clk) begin
    if (busy) begin
      r_mem[r_clr_cnt] <= CLR_VAL;
    end else if (r_s1_valid && r_s1_we) begin
      r_mem[r_s1_addr] <= (r_mem[r_s1_addr] & ~r_s1_wmask) | (r_s1_wdata & r_s1_wmask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid0 <= 1'b0;
      r_rd_data0  <= '0;
    end else begin
      r_rd_valid0 <= r_s1_valid & ~r_s1_we;
      if (r_s1_valid && !r_s1_we) begin
        r_rd_data0 <= r_mem[r_s1_addr];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              r_rd_valid1;
      logic [DATA_W-1:0] r_rd_data1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_valid1 <= 1'b0;
          r_rd_data1  <= '0;
        end else begin
          r_rd_valid1 <= r_rd_valid0;
          if (r_rd_valid0) begin
            r_rd_data1 <= r_rd_data0;
          end
        end
      end

      assign rd_valid = r_rd_valid1;
      assign rd_data  = r_rd_data1;
    end else begin : g_no_out_reg
      assign rd_valid = r_rd_valid0;
      assign rd_data  = r_rd_data0;
    end
  endgenerate

endmodule
